// File: rtl/ysyx_040750_trap_ctrl_if.sv
// Commit-stage, CSR and fetch-redirect signals shared between the core
// pipeline (master) and the trap controller (slave).
interface ysyx_040750_trap_ctrl_if;
   logic        I_WB_valid;
   logic        I_WB_ecall;
   logic        I_WB_mret;
   logic [31:0] I_WB_pc;
   logic        I_timer_intr;
   logic        I_pipe_empty;
   logic [31:0] I_next_pc;
   logic [63:0] I_csr_rd_data;
   logic        I_redirect_ready;

   logic        O_stall;
   logic        O_flush;
   logic        O_csr_intr_wr;
   logic        O_csr_intr_rd;
   logic        O_csr_mret_wr;
   logic        O_csr_mret_rd;
   logic        O_csr_commit;
   logic [31:0] O_intr_pc;
   logic [63:0] O_intr_no;
   logic        O_redirect_valid;
   logic [31:0] O_redirect_pc;
   logic        O_drain_err;

   modport master (
      output I_WB_valid, I_WB_ecall, I_WB_mret, I_WB_pc, I_timer_intr,
             I_pipe_empty, I_next_pc, I_csr_rd_data, I_redirect_ready,
      input  O_stall, O_flush, O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr,
             O_csr_mret_rd, O_csr_commit, O_intr_pc, O_intr_no,
             O_redirect_valid, O_redirect_pc, O_drain_err
   );

   modport slave (
      input  I_WB_valid, I_WB_ecall, I_WB_mret, I_WB_pc, I_timer_intr,
             I_pipe_empty, I_next_pc, I_csr_rd_data, I_redirect_ready,
      output O_stall, O_flush, O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr,
             O_csr_mret_rd, O_csr_commit, O_intr_pc, O_intr_no,
             O_redirect_valid, O_redirect_pc, O_drain_err
   );
endinterface

// File: rtl/ysyx_040750_trap_ctrl.sv
// Trap / mret sequencer: drains the pipe for timer interrupts, pulses the
// CSR save/restore strobes for one cycle, then redirects fetch.
//
// state | meaning
// IDLE  | no trap activity, pipeline runs freely
// DRAIN | timer pending, fetch held until the pipe is empty
// TRAP  | one cycle: save mepc/mcause, read mtvec, flush
// MRET  | one cycle: read mepc, flush
// REDIR | redirect target presented until fetch accepts it
module ysyx_040750_trap_ctrl #(
   parameter logic [63:0] ECALL_CAUSE = 64'd11,
   parameter logic [63:0] TIMER_CAUSE = 64'h8000_0000_0000_0007,
   parameter int unsigned DRAIN_MAX   = 32
) (
   input logic                    I_sys_clk,
   input logic                    I_rst,
   ysyx_040750_trap_ctrl_if.slave bus
);
   localparam int unsigned      CNT_W    = $clog2(DRAIN_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRAIN = 3'd1,
      TRAP  = 3'd2,
      MRET  = 3'd3,
      REDIR = 3'd4
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] drain_cnt_q;
   logic [31:0]      epc_q;
   logic [63:0]      cause_q;
   logic [31:0]      redir_pc_q;
   logic             redir_valid_q;
   logic             stall_q;
   logic             flush_q;
   logic             intr_wr_q;
   logic             intr_rd_q;
   logic             mret_wr_q;
   logic             mret_rd_q;
   logic             commit_q;
   logic             drain_err_q;

   logic             can_take_d;
   logic             take_ecall_d;
   logic             take_mret_d;
   logic             take_timer_d;
   logic             drop_timer_d;
   logic             enter_trap_d;
   logic [31:0]      trap_epc_d;
   logic [63:0]      trap_cause_d;
   logic [31:0]      mtvec_pc_d;
   logic [31:0]      mepc_pc_d;
   logic [31:0]      unused_csr_hi;

   // Commits outrank the timer: ecall first, then mret, in IDLE and DRAIN alike.
   always_comb begin
      can_take_d   = (state_q == IDLE) || (state_q == DRAIN);
      take_ecall_d = can_take_d && bus.I_WB_valid && bus.I_WB_ecall;
      take_mret_d  = can_take_d && bus.I_WB_valid && bus.I_WB_mret && !bus.I_WB_ecall;
      take_timer_d = 1'b0;
      drop_timer_d = 1'b0;
      if ((state_q == DRAIN) && !take_ecall_d && !take_mret_d && bus.I_pipe_empty) begin
         take_timer_d = bus.I_timer_intr;
         drop_timer_d = !bus.I_timer_intr;
      end
      enter_trap_d = take_ecall_d || take_timer_d;
      trap_epc_d   = take_timer_d ? bus.I_next_pc : bus.I_WB_pc;
      trap_cause_d = take_timer_d ? TIMER_CAUSE : ECALL_CAUSE;
      mtvec_pc_d   = {bus.I_csr_rd_data[31:2], 2'b00};
      mepc_pc_d    = bus.I_csr_rd_data[31:0];
   end

   assign unused_csr_hi = bus.I_csr_rd_data[63:32];

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         state_q       <= IDLE;
         drain_cnt_q   <= '0;
         epc_q         <= '0;
         cause_q       <= '0;
         redir_pc_q    <= '0;
         redir_valid_q <= 1'b0;
         stall_q       <= 1'b0;
         flush_q       <= 1'b0;
         intr_wr_q     <= 1'b0;
         intr_rd_q     <= 1'b0;
         mret_wr_q     <= 1'b0;
         mret_rd_q     <= 1'b0;
         commit_q      <= 1'b0;
         drain_err_q   <= 1'b0;
      end else begin
         flush_q     <= 1'b0;
         intr_wr_q   <= 1'b0;
         intr_rd_q   <= 1'b0;
         mret_wr_q   <= 1'b0;
         mret_rd_q   <= 1'b0;
         commit_q    <= 1'b0;
         drain_err_q <= 1'b0;
         unique case (state_q)
            IDLE, DRAIN: begin
               if (enter_trap_d) begin
                  state_q   <= TRAP;
                  epc_q     <= trap_epc_d;
                  cause_q   <= trap_cause_d;
                  intr_wr_q <= 1'b1;
                  intr_rd_q <= 1'b1;
                  commit_q  <= 1'b1;
                  flush_q   <= 1'b1;
                  stall_q   <= 1'b1;
               end else if (take_mret_d) begin
                  state_q   <= MRET;
                  mret_wr_q <= 1'b1;
                  mret_rd_q <= 1'b1;
                  commit_q  <= 1'b1;
                  flush_q   <= 1'b1;
                  stall_q   <= 1'b1;
               end else if (state_q == IDLE) begin
                  if (bus.I_timer_intr) begin
                     state_q     <= DRAIN;
                     stall_q     <= 1'b1;
                     drain_cnt_q <= CNT_LOAD;
                  end
               end else if (drop_timer_d) begin
                  state_q <= IDLE;
                  stall_q <= 1'b0;
               end else begin
                  // Timeout is reported once; the drain keeps waiting afterwards.
                  if (drain_cnt_q != '0) begin
                     drain_cnt_q <= drain_cnt_q - CNT_ONE;
                  end
                  drain_err_q <= (drain_cnt_q == CNT_ONE);
               end
            end
            TRAP: begin
               redir_pc_q    <= mtvec_pc_d;
               redir_valid_q <= 1'b1;
               state_q       <= REDIR;
            end
            MRET: begin
               redir_pc_q    <= mepc_pc_d;
               redir_valid_q <= 1'b1;
               state_q       <= REDIR;
            end
            REDIR: begin
               if (bus.I_redirect_ready) begin
                  redir_valid_q <= 1'b0;
                  stall_q       <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: begin
               state_q       <= IDLE;
               redir_valid_q <= 1'b0;
               stall_q       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.O_stall          = stall_q;
   assign bus.O_flush          = flush_q;
   assign bus.O_csr_intr_wr    = intr_wr_q;
   assign bus.O_csr_intr_rd    = intr_rd_q;
   assign bus.O_csr_mret_wr    = mret_wr_q;
   assign bus.O_csr_mret_rd    = mret_rd_q;
   assign bus.O_csr_commit     = commit_q;
   assign bus.O_intr_pc        = epc_q;
   assign bus.O_intr_no        = cause_q;
   assign bus.O_redirect_valid = redir_valid_q;
   assign bus.O_redirect_pc    = redir_pc_q;
   assign bus.O_drain_err      = drain_err_q;
endmodule

// File: tb/tb_ysyx_040750_trap_ctrl.sv
// Scoreboard bench for ysyx_040750_trap_ctrl: stimulus tasks push expected
// events (trap, mret, redirect, drain timeout) with their due cycle.
module tb_ysyx_040750_trap_ctrl;
   localparam int unsigned DMAX    = 32;
   localparam logic [63:0] ECALL_C = 64'd11;
   localparam logic [63:0] TIMER_C = 64'h8000_0000_0000_0007;
   localparam int EV_TRAP  = 0;
   localparam int EV_MRET  = 1;
   localparam int EV_REDIR = 2;
   localparam int EV_DERR  = 3;

   typedef struct {
      int          kind;
      int unsigned due;
      logic [31:0] pc;
      logic [63:0] cause;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] mtvec_v = 64'd0;
   logic [63:0] mepc_v  = 64'd0;
   ev_t         exp_q[$];
   ev_t         dummy;

   ysyx_040750_trap_ctrl_if bus ();

   ysyx_040750_trap_ctrl #(.DRAIN_MAX(DMAX)) dut (
      .I_sys_clk(clk),
      .I_rst    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // CSR file model: the read port returns whichever CSR the controller selects.
   assign bus.I_csr_rd_data = bus.O_csr_intr_rd ? mtvec_v :
                              bus.O_csr_mret_rd ? mepc_v  : 64'h0bad_0bad_0bad_0bad;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int unsigned due, input logic [31:0] pc,
                          input logic [63:0] cause);
      ev_t e;
      e.kind  = kind;
      e.due   = due;
      e.pc    = pc;
      e.cause = cause;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.I_WB_valid       = 1'b0;
      bus.I_WB_ecall       = 1'b0;
      bus.I_WB_mret        = 1'b0;
      bus.I_timer_intr     = 1'b0;
      bus.I_redirect_ready = 1'b0;
      bus.I_pipe_empty     = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, 64'({bus.O_stall, bus.O_flush, bus.O_csr_intr_wr, bus.O_csr_intr_rd,
                                 bus.O_csr_mret_wr, bus.O_csr_mret_rd, bus.O_csr_commit,
                                 bus.O_redirect_valid, bus.O_drain_err}), 64'd0);
      check({tag, "_intr_pc"}, 64'(bus.O_intr_pc), 64'd0);
      check({tag, "_intr_no"}, bus.O_intr_no, 64'd0);
      check({tag, "_redirect_pc"}, 64'(bus.O_redirect_pc), 64'd0);
   endtask

   // Called in the TRAP/MRET cycle; fetch accepts after 'delay' redirect cycles.
   task automatic finish_redirect(input int unsigned delay, input bit noise);
      int unsigned h;
      h = cyc + 1 + delay;
      bus.I_WB_valid   = noise;
      bus.I_WB_ecall   = noise;
      bus.I_WB_mret    = noise;
      bus.I_timer_intr = noise;
      bus.I_pipe_empty = 1'b1;
      while (cyc <= h) begin
         bus.I_redirect_ready = (cyc == h);
         tick();
      end
      quiet();
      check("stall_after_redirect", 64'(bus.O_stall), 64'd0);
      check("redirect_valid_after", 64'(bus.O_redirect_valid), 64'd0);
   endtask

   task automatic do_commit(input bit is_ecall, input logic [31:0] pc, input logic [63:0] csrval,
                            input int unsigned delay, input bit noise);
      int unsigned t;
      t = cyc;
      bus.I_WB_valid   = 1'b1;
      bus.I_WB_ecall   = is_ecall;
      bus.I_WB_mret    = is_ecall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.I_WB_pc      = pc;
      bus.I_timer_intr = 1'($urandom_range(0, 1));
      bus.I_pipe_empty = 1'($urandom_range(0, 1));
      if (is_ecall) begin
         mtvec_v = csrval;
         push_ev(EV_TRAP, t + 1, pc, ECALL_C);
         push_ev(EV_REDIR, t + 2 + delay, {csrval[31:2], 2'b00}, 64'd0);
      end else begin
         mepc_v = csrval;
         push_ev(EV_MRET, t + 1, 32'd0, 64'd0);
         push_ev(EV_REDIR, t + 2 + delay, csrval[31:0], 64'd0);
      end
      tick();
      finish_redirect(delay, noise);
   endtask

   // Timer raised in cycle t; pipe reports empty in cycle t+wait_n.
   task automatic do_timer(input int unsigned wait_n, input bit drop, input logic [31:0] npc,
                           input logic [63:0] csrval, input int unsigned delay);
      int unsigned t;
      t = cyc;
      bus.I_timer_intr = 1'b1;
      bus.I_pipe_empty = 1'b0;
      bus.I_WB_valid   = 1'b0;
      bus.I_next_pc    = $urandom;
      mtvec_v          = csrval;
      if (wait_n > DMAX) push_ev(EV_DERR, t + DMAX + 1, 32'd0, 64'd0);
      if (!drop) begin
         push_ev(EV_TRAP, t + wait_n + 1, npc, TIMER_C);
         push_ev(EV_REDIR, t + wait_n + 2 + delay, {csrval[31:2], 2'b00}, 64'd0);
      end
      tick();
      check("stall_drain_first", 64'(bus.O_stall), 64'd1);
      if (drop) bus.I_timer_intr = 1'b0;
      while (cyc < t + wait_n) begin
         bus.I_WB_valid = 1'($urandom_range(0, 1));
         tick();
      end
      bus.I_WB_valid   = 1'b0;
      bus.I_pipe_empty = 1'b1;
      bus.I_next_pc    = npc;
      check("stall_drain_last", 64'(bus.O_stall), 64'd1);
      tick();
      if (drop) begin
         quiet();
         check("stall_after_drop", 64'(bus.O_stall), 64'd0);
      end else begin
         finish_redirect(delay, 1'b0);
      end
   endtask

   // Ecall commits k cycles into a timer drain, timer still asserted.
   task automatic do_collision(input int unsigned k, input logic [31:0] pc,
                               input logic [63:0] csrval, input int unsigned delay);
      int unsigned t;
      t = cyc;
      bus.I_timer_intr = 1'b1;
      bus.I_pipe_empty = 1'b0;
      bus.I_WB_valid   = 1'b0;
      tick();
      while (cyc < t + k) tick();
      bus.I_WB_valid   = 1'b1;
      bus.I_WB_ecall   = 1'b1;
      bus.I_WB_mret    = 1'($urandom_range(0, 1));
      bus.I_WB_pc      = pc;
      bus.I_pipe_empty = 1'b1;
      bus.I_next_pc    = pc ^ 32'h0000_0040;
      mtvec_v          = csrval;
      push_ev(EV_TRAP, t + k + 1, pc, ECALL_C);
      push_ev(EV_REDIR, t + k + 2 + delay, {csrval[31:2], 2'b00}, 64'd0);
      tick();
      finish_redirect(delay, 1'b1);
   endtask

   always @(negedge clk) begin : monitor
      logic [5:0] strb;
      logic [5:0] want;
      ev_t        e;
      if (!rst) begin
         strb = {bus.O_csr_intr_wr, bus.O_csr_intr_rd, bus.O_csr_mret_wr,
                 bus.O_csr_mret_rd, bus.O_csr_commit, bus.O_flush};
         if (strb != 6'b0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_csr_strobe", 64'(strb), 64'd0);
            end else begin
               e = exp_q.pop_front();
               want = (e.kind == EV_TRAP) ? 6'b110011 :
                      (e.kind == EV_MRET) ? 6'b001111 : 6'b000000;
               check("csr_strobes", 64'(strb), 64'(want));
               check("trap_cycle", 64'(cyc), 64'(e.due));
               check("stall_in_trap", 64'(bus.O_stall), 64'd1);
               if (e.kind == EV_TRAP) begin
                  check("intr_pc", 64'(bus.O_intr_pc), 64'(e.pc));
                  check("intr_no", bus.O_intr_no, e.cause);
               end
            end
         end
         if (bus.O_redirect_valid) begin
            if (exp_q.size() == 0 || exp_q[0].kind != EV_REDIR) begin
               check("unexpected_redirect", 64'(bus.O_redirect_valid), 64'd0);
            end else begin
               check("redirect_pc", 64'(bus.O_redirect_pc), 64'(exp_q[0].pc));
               check("stall_in_redirect", 64'(bus.O_stall), 64'd1);
               if (bus.I_redirect_ready) begin
                  e = exp_q.pop_front();
                  check("redirect_cycle", 64'(cyc), 64'(e.due));
               end
            end
         end
         if (bus.O_drain_err) begin
            if (exp_q.size() == 0 || exp_q[0].kind != EV_DERR) begin
               check("unexpected_drain_err", 64'(bus.O_drain_err), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("drain_err_cycle", 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      quiet();
      bus.I_WB_pc   = 32'd0;
      bus.I_next_pc = 32'd0;
      rst = 1'b1;
      repeat (3) tick();
      check_all_zero("in_reset");
      rst = 1'b0;
      tick();
      check_all_zero("after_reset");

      do_commit(1'b1, 32'h8000_0010, 64'h0000_0000_8000_0101, 0, 1'b0);
      tick();
      do_timer(3, 1'b0, 32'h8000_0040, 64'h0000_0000_8000_0200, 0);
      tick();
      do_commit(1'b0, 32'h8000_0020, 64'h0000_0000_8000_0044, 2, 1'b0);
      tick();
      do_collision(2, 32'h8000_0050, 64'h0000_0000_8000_0300, 1);
      tick();
      do_timer(4, 1'b1, 32'h8000_0060, 64'h0000_0000_8000_0400, 0);
      tick();
      do_timer(DMAX + 8, 1'b1, 32'h8000_0070, 64'h0000_0000_8000_0500, 0);
      tick();
      do_timer(DMAX + 3, 1'b0, 32'h8000_0080, 64'h0000_0000_8000_0600, 1);
      tick();

      // Reset in the middle of a redirect wait.
      begin
         int unsigned t;
         t = cyc;
         bus.I_WB_valid = 1'b1;
         bus.I_WB_ecall = 1'b1;
         bus.I_WB_mret  = 1'b0;
         bus.I_WB_pc    = 32'h8000_0100;
         mtvec_v        = 64'h0000_0000_8000_0300;
         push_ev(EV_TRAP, t + 1, 32'h8000_0100, ECALL_C);
         push_ev(EV_REDIR, t + 1000, 32'h8000_0300, 64'd0);
         tick();
         quiet();
         tick();
         tick();
         check("redirect_valid_held", 64'(bus.O_redirect_valid), 64'd1);
         rst = 1'b1;
         tick();
         dummy = exp_q.pop_back();
         check_all_zero("reset_mid_redirect");
         rst = 1'b0;
         tick();
         check_all_zero("idle_after_reset");
         do_commit(1'b1, 32'h8000_0010, 64'h0000_0000_8000_0101, 1, 1'b0);
         tick();
      end

      // Reset in the middle of a drain; no timeout or trap may follow.
      bus.I_timer_intr = 1'b1;
      bus.I_pipe_empty = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      quiet();
      tick();
      rst = 1'b0;
      check_all_zero("reset_mid_drain");
      repeat (DMAX + 4) tick();
      check("stall_idle_after_drain_reset", 64'(bus.O_stall), 64'd0);

      for (int i = 0; i < 150; i++) begin
         int unsigned sel;
         int unsigned dly;
         sel = $urandom_range(0, 3);
         dly = $urandom_range(0, 3);
         case (sel)
            0: do_commit(1'b1, $urandom, {$urandom, $urandom}, dly, 1'($urandom_range(0, 1)));
            1: do_commit(1'b0, $urandom, {$urandom, $urandom}, dly, 1'($urandom_range(0, 1)));
            2: do_timer($urandom_range(1, 6), ($urandom_range(0, 3) == 0), $urandom,
                        {$urandom, $urandom}, dly);
            default: do_collision($urandom_range(1, 5), $urandom, {$urandom, $urandom}, dly);
         endcase
         tick();
      end

      repeat (4) tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_040750_trap_ctrl.md
YSYX_040750_TRAP_CTRL -- requirements
Module: ysyx_040750_trap_ctrl

Interface
REQ-001 SHALL provide parameter ECALL_CAUSE, default 64'd11, mcause value for environment call from M-mode.
REQ-002 SHALL provide parameter TIMER_CAUSE, default 64'h8000_0000_0000_0007, mcause value for machine timer interrupt.
REQ-003 SHALL provide parameter DRAIN_MAX, default 32, maximum DRAIN cycles before O_drain_err pulses.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 I_sys_clk  in  1  system clock.
REQ-006 I_rst  in  1  synchronous active-high reset.
REQ-007 I_WB_valid  in  1  an instruction commits this cycle.
REQ-008 I_WB_ecall  in  1  committing instruction is ecall; meaningful only with I_WB_valid.
REQ-009 I_WB_mret  in  1  committing instruction is mret; meaningful only with I_WB_valid.
REQ-010 I_WB_pc  in  32  PC of committing instruction.
REQ-011 I_timer_intr  in  1  pending enabled timer interrupt from the CSR file.
REQ-012 I_pipe_empty  in  1  no valid instruction in ID/EX/MEM/WB.
REQ-013 I_next_pc  in  32  PC of the oldest unfetched/uncommitted instruction; valid when I_pipe_empty.
REQ-014 I_csr_rd_data  in  64  combinational CSR read data (mtvec or mepc).
REQ-015 I_redirect_ready  in  1  fetch unit accepts redirect.
REQ-016 O_stall  out  1  hold fetch; no new instruction enters the pipeline.
REQ-017 O_flush  out  1  one-cycle pulse; kill all in-flight instructions.
REQ-018 O_csr_intr_wr, O_csr_intr_rd  out  1 each  trap-entry CSR write / mtvec read select.
REQ-019 O_csr_mret_wr, O_csr_mret_rd  out  1 each  mret CSR write / mepc read select.
REQ-020 O_csr_commit  out  1  CSR write qualifier, ORed by top level into the CSR valid input.
REQ-021 O_intr_pc  out  32  mepc value to save.
REQ-022 O_intr_no  out  64  mcause value to save.
REQ-023 O_redirect_valid  out  1  redirect request to fetch.
REQ-024 O_redirect_pc  out  32  redirect target.
REQ-025 O_drain_err  out  1  one-cycle pulse on drain timeout.

Function
REQ-026 FSM states SHALL be IDLE, DRAIN, TRAP, MRET, REDIR.
REQ-027 IDLE: if I_WB_valid & I_WB_ecall, go to TRAP, latching epc=I_WB_pc and cause=ECALL_CAUSE; else if I_WB_valid & I_WB_mret, go to MRET; else if I_timer_intr, go to DRAIN. Priority: ecall > mret > timer.
REQ-028 DRAIN: O_stall=1; an ecall or mret commit SHALL be handled as in IDLE, with the same priority.
REQ-029 DRAIN, otherwise: when I_pipe_empty and I_timer_intr, go to TRAP with epc=I_next_pc and cause=TIMER_CAUSE; when I_pipe_empty and !I_timer_intr, return to IDLE and drop the interrupt.
REQ-030 DRAIN cycle counter SHALL reset on DRAIN entry and saturate; O_drain_err SHALL pulse once when it reaches DRAIN_MAX while still in DRAIN; the FSM keeps waiting.
REQ-031 TRAP, exactly one cycle: O_csr_intr_wr, O_csr_intr_rd, O_csr_commit, O_flush and O_stall SHALL be 1, with O_intr_pc/O_intr_no driven from the latches.
REQ-032 TRAP SHALL latch redirect target {I_csr_rd_data[31:2],2'b00} (mtvec, direct mode), then go to REDIR.
REQ-033 MRET, exactly one cycle: O_csr_mret_wr, O_csr_mret_rd, O_csr_commit, O_flush and O_stall SHALL be 1.
REQ-034 MRET SHALL latch redirect target I_csr_rd_data[31:0] (mepc), then go to REDIR.
REQ-035 REDIR: O_stall=1 and O_redirect_valid=1, with O_redirect_pc stable until I_redirect_ready; the handshake cycle returns to IDLE, with O_stall low the next cycle.
REQ-036 I_timer_intr, ecall and mret SHALL be ignored in TRAP, MRET and REDIR.
REQ-037 Redirect latency SHALL be 2 cycles: trigger cycle, then TRAP/MRET, then O_redirect_valid, when I_redirect_ready=1.
REQ-038 CSR strobes SHALL never be asserted together and never outside TRAP/MRET.

Reset
REQ-039 I_rst SHALL force IDLE in any state, including mid-DRAIN and mid-REDIR, clearing the counter and latches.
REQ-040 During and after I_rst, all outputs SHALL be 0 until the next trigger.

Verification
REQ-041 Ecall: I_WB_valid=1, I_WB_ecall=1, I_WB_pc=0x80000010, mtvec=0x80000101 -> next cycle intr_wr/rd, commit, flush, O_intr_pc=0x80000010, O_intr_no=11; then O_redirect_pc=0x80000100.
REQ-042 Timer: I_timer_intr=1, pipe non-empty 3 cycles, then I_pipe_empty=1 with I_next_pc=0x80000040 -> O_stall high 3 cycles, then TRAP with O_intr_no=0x8000000000000007 and O_intr_pc=0x80000040.
REQ-043 Mret: commit, mepc=0x80000044, I_redirect_ready low 2 cycles -> mret_wr/rd pulse; O_redirect_valid held 3 cycles with pc=0x80000044; IDLE after ready.
REQ-044 Collision: ecall commit in DRAIN while timer pending -> ECALL_CAUSE taken; timer not taken in that sequence.
REQ-045 Edge: timer drops before drain completes -> return to IDLE with no CSR strobes; pipe never empties for 32 cycles -> single O_drain_err pulse.
REQ-046 Reset: I_rst asserted during REDIR -> next cycle IDLE, all outputs 0, and a later ecall handled normally.
